// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared segment types, bit order and hex pattern table
package seg_pkg;

    // Segment vector, bit 6 = a ... bit 0 = g, active-high.
    typedef logic [6:0] seg_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Glyphs for 0-9, A, b, C, d, E, F.
    localparam seg_t SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to 7-segment pattern
// Ports: nibble_i (4-bit hex digit), seg_o (active-high {a..g} pattern).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - multiplexed 7-segment scan driver with frame-synchronous updates
// Ports: clk, rst_n (async active-low); load/value/dp capture a new display image;
// blank_lz enables leading-zero blanking; enable runs the scan;
// seg/dp_out/an are registered pin-level outputs; frame_done pulses once per full scan.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic          SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic          AN_INV   = (AN_ACTIVE_LOW != 0);

    // Pin-level inactive values, used for reset and for idle/blanked slots.
    localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_INV}};

    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0]   shadow_dp_q,  shadow_dp_d;
    logic                pend_q,       pend_d;
    logic [4*DIGITS-1:0] disp_val_q,   disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q,    disp_dp_d;
    logic [CW-1:0]       cnt_q,        cnt_d;
    logic [IW-1:0]       idx_q,        idx_d;
    logic [6:0]          seg_q,        seg_d;
    logic                dp_out_q,     dp_out_d;
    logic [DIGITS-1:0]   an_q,         an_d;
    logic                fd_q,         fd_d;

    logic                last_cnt;
    logic                boundary;
    logic [DIGITS-1:0]   blank_vec;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    seg_t                dec_seg;
    logic                show;
    logic                an_on;

    // Prescaler and digit index; a frame boundary is the last count of the last digit.
    always_comb begin
        last_cnt = (cnt_q == CNT_LAST);
        boundary = enable && last_cnt && (idx_q == IDX_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (last_cnt) begin
            cnt_d = '0;
            idx_d = boundary ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Shadow collects loads; display only changes on a frame boundary so a
    // frame never mixes old and new digits. A load landing exactly on the
    // boundary goes straight to the display.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_d       = pend_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp;
        end
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp;
            end else if (pend_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is blanked while every
    // nibble from it upward is zero. Digit 0 always shows.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (disp_val_q[4*k +: 4] == 4'h0);
            blank_vec[k] = blank_lz & zero_run & (k != 0);
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = blank_vec[k];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    // Segments follow the digit for the whole slot; the anode only opens after
    // the dead cycles, so segment changes happen while every anode is off.
    always_comb begin
        show     = enable & ~cur_blank;
        an_on    = show & (cnt_q >= CNT_ON);
        seg_d    = (show ? dec_seg : 7'b0) ^ SEG_OFF;
        dp_out_d = (show & cur_dp) ^ SEG_INV;
        an_d     = (an_on ? (DIGITS'(1) << idx_q) : '0) ^ AN_OFF;
        fd_d     = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_q       <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_OFF;
            dp_out_q     <= SEG_INV;
            an_q         <= AN_OFF;
            fd_q         <= 1'b0;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_q       <= pend_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic        enable = 1'b1;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS         (4),
        .PRESCALE       (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank_lz   (blank_lz),
        .enable     (enable),
        .seg        (seg),
        .dp_out     (dp_out),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Model: s is the number of cycles since the scan (re)started; the digit
    // and the position in its slot follow from plain division.
    int          m_s = 0;
    logic [15:0] m_disp = 16'h0, m_sh = 16'h0;
    logic [3:0]  m_ddp = 4'h0, m_shdp = 4'h0;
    logic        m_pend = 1'b0;
    logic [3:0]  e_an = 4'hF;
    logic [6:0]  e_seg = 7'h0;
    logic        e_dp = 1'b0, e_fd = 1'b0;
    logic        m_bnd;

    assign m_bnd = enable && (m_s % 32 == 31);

    function automatic logic f_blank(input int s, input logic [15:0] disp, input logic blz);
        int d;
        d = (s / 8) % 4;
        return blz && (d > 0) && ((disp >> (4 * d)) == 16'h0);
    endfunction

    function automatic logic [3:0] f_an(input int s, input logic [15:0] disp, input logic blz, input logic en);
        int d;
        d = (s / 8) % 4;
        if (!en || (s % 8) < 2 || f_blank(s, disp, blz)) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [6:0] f_seg(input int s, input logic [15:0] disp, input logic blz, input logic en);
        logic [15:0] t;
        if (!en || f_blank(s, disp, blz)) return 7'h0;
        t = disp >> (4 * ((s / 8) % 4));
        return hexseg(t[3:0]);
    endfunction

    function automatic logic f_dp(input int s, input logic [15:0] disp, input logic [3:0] dpv,
                                  input logic blz, input logic en);
        if (!en || f_blank(s, disp, blz)) return 1'b0;
        return dpv[(s / 8) % 4];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s    <= 0;
            m_disp <= 16'h0;
            m_ddp  <= 4'h0;
            m_sh   <= 16'h0;
            m_shdp <= 4'h0;
            m_pend <= 1'b0;
            e_an   <= 4'hF;
            e_seg  <= 7'h0;
            e_dp   <= 1'b0;
            e_fd   <= 1'b0;
        end else begin
            e_an   <= f_an(m_s, m_disp, blank_lz, enable);
            e_seg  <= f_seg(m_s, m_disp, blank_lz, enable);
            e_dp   <= f_dp(m_s, m_disp, m_ddp, blank_lz, enable);
            e_fd   <= m_bnd;
            m_sh   <= load ? value : m_sh;
            m_shdp <= load ? dp : m_shdp;
            m_disp <= (m_bnd && load) ? value : (m_bnd && m_pend) ? m_sh : m_disp;
            m_ddp  <= (m_bnd && load) ? dp : (m_bnd && m_pend) ? m_shdp : m_ddp;
            m_pend <= m_bnd ? 1'b0 : (load ? 1'b1 : m_pend);
            m_s    <= enable ? m_s + 1 : 0;
        end
    end

    always @(negedge clk) begin
        check("model_an", an, e_an);
        check("model_seg", seg, e_seg);
        check("model_dp", dp_out, e_dp);
        check("model_fd", frame_done, e_fd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] pat, input string name);
        int n;
        n = 0;
        while (an !== pat && n < 100) begin
            step();
            n++;
        end
        if (an !== pat) check(name, an, pat);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) check("fd_timeout", frame_done, 1);
    endtask

    initial begin
        int  bad, cnt2, n;
        time t0, t1;
        logic [6:0] s0, s1;

        // Reset
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h0);
        check("rst_dp", dp_out, 0);
        check("rst_fd", frame_done, 0);
        rst_n = 1'b1;
        step(); check("rel_an1", an, 4'hF);
        step(); check("rel_an2", an, 4'hF);
        step(); check("rel_an3", an, 4'b1110);
        check("rel_seg0", seg, 7'b1111110);

        // Decode
        do_load(16'h12A0, 4'b0100);
        repeat (64) step();
        wait_an(4'b1110, "dec_wait0"); check("dec_seg0", seg, 7'b1111110); check("dec_dp0", dp_out, 0);
        wait_an(4'b1101, "dec_wait1"); check("dec_seg1", seg, 7'b1110111);
        wait_an(4'b1011, "dec_wait2"); check("dec_seg2", seg, 7'b1101101); check("dec_dp2", dp_out, 1);
        wait_an(4'b0111, "dec_wait3"); check("dec_seg3", seg, 7'b0110000);
        wait_fd(); t0 = $time;
        wait_fd(); t1 = $time;
        check("fd_period", 32'((t1 - t0) / 10), 32);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_fd(); wait_fd();
        bad = 0; s0 = 7'h0; s1 = 7'h0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (an == 4'b0111 || an == 4'b1011) bad++;
            if (an == 4'b1101) s1 = seg;
            if (an == 4'b1110) s0 = seg;
        end
        check("blz_hi_digits", bad, 0);
        check("blz_seg1", s1, 7'b1011011);
        check("blz_seg0", s0, 7'b1111110);
        do_load(16'h0000, 4'h0);
        wait_fd(); wait_fd();
        bad = 0; s0 = 7'h0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (an != 4'hF && an != 4'b1110) bad++;
            if (an == 4'b1110) s0 = seg;
        end
        check("blz_zero_only0", bad, 0);
        check("blz_zero_seg0", s0, 7'b1111110);
        blank_lz = 1'b0;

        // Tear-free update
        wait_fd();
        repeat (5) step();
        do_load(16'h1111, 4'h0);
        repeat (5) step();
        do_load(16'h2222, 4'h0);
        bad = 0; n = 0;
        do begin
            step();
            n++;
            if (an != 4'hF && seg != 7'b1111110) bad++;
        end while (!frame_done && n < 100);
        check("tear_fd_seen", frame_done, 1);
        check("tear_old_kept", bad, 0);
        bad = 0; cnt2 = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (an != 4'hF && seg == 7'b0110000) bad++;
            if (an != 4'hF && seg == 7'b1101101) cnt2++;
        end
        check("tear_no_one", bad, 0);
        check("tear_all_two", cnt2, 24);

        // Load on the boundary cycle
        wait_fd();
        repeat (31) step();
        do_load(16'h3333, 4'h0);
        check("bnd_fd", frame_done, 1);
        step();
        check("bnd_seg0", seg, 7'b1111001);

        // Enable drop and restart
        wait_an(4'b1011, "en_wait2");
        enable = 1'b0;
        step();
        check("en_off_an", an, 4'hF);
        check("en_off_seg", seg, 7'h0);
        repeat (4) step();
        enable = 1'b1;
        step(); check("en_re_an1", an, 4'hF);
        step(); check("en_re_an2", an, 4'hF);
        step(); check("en_re_an3", an, 4'b1110);
        check("en_re_seg", seg, 7'b1111001);

        // Asynchronous reset between edges
        wait_an(4'b1101, "ar_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_an", an, 4'hF);
        check("ar_seg", seg, 7'h0);
        step();
        rst_n = 1'b1;
        wait_an(4'b1110, "ar_wait0");
        check("ar_disp0", seg, 7'b1111110);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment display driver: holds a DIGITS-wide hex value and scans it onto a shared segment bus with one anode enable per digit. It adds decimal points, leading-zero blanking, anti-ghosting dead time, selectable output polarity and tear-free frame-synchronous updates. It sits between the datapath producing display values and the board pins, and replaces single-digit per-pin decoding.

## Interface
- DIGITS, 4: number of digits, 1..16.
- PRESCALE, 1000: clk cycles per digit slot, at least BLANK_CYCLES+1.
- BLANK_CYCLES, 2: dead cycles at the start of each slot with all anodes off, at least 0.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp_out at the pins.
- AN_ACTIVE_LOW, 1: 1 makes an active-low.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  capture value/dp this cycle.
- value  in  4*DIGITS  hex nibbles; digit k is value[4k+3:4k]; digit 0 is rightmost.
- dp  in  DIGITS  decimal point per digit.
- blank_lz  in  1  leading-zero blanking enable.
- enable  in  1  scanning enable.
- seg  out  7  {a,b,c,d,e,f,g}, registered.
- dp_out  out  1  decimal point of the current digit, registered.
- an  out  DIGITS  digit enables, one-hot when active, registered.
- frame_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- Segment map, active-high before polarity is applied:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Registers:
  - shadow (value+dp) and pending flag.
  - display (value+dp).
  - prescale counter (width $clog2(PRESCALE)).
  - digit index (width $clog2(DIGITS), min 1).
- load=1: shadow takes value/dp and pending is set. Repeated loads before a frame boundary overwrite the shadow; the last one wins.
- Frame boundary is the terminal prescale count (PRESCALE-1) while index=DIGITS-1. At the boundary:
  - index wraps to 0.
  - If pending, display takes shadow and pending clears.
  - If load is high in the boundary cycle, display takes the incoming value/dp directly and pending stays 0.
- Other terminal counts: index increments.
- Leading-zero blanking: digit k is blanked when blank_lz=1, k>0, and nibbles k..DIGITS-1 of display are all zero. A blanked digit drives its anode inactive and seg/dp off, even if its dp bit is set. Digit 0 is never blanked.
- enable=0: prescale counter and index are held at 0; an, seg and dp_out are inactive; frame_done=0. Load and shadow still operate, but no boundary occurs, so display is frozen. When enable returns to 1, scanning restarts at digit 0, count 0.
- Reset values: an all inactive (all 1 when AN_ACTIVE_LOW); seg and dp_out inactive (0 when SEG_ACTIVE_LOW=0); frame_done=0; shadow, display, pending, counter and index all 0.

## Timing
- The pins lag internal state by 1 cycle because all outputs are registered.
- Each digit slot is PRESCALE cycles long.
  - Its anode is active for counts BLANK_CYCLES..PRESCALE-1, as seen one cycle later at the pins.
  - seg/dp_out change only while all anodes are inactive when BLANK_CYCLES≥1.
- Full frame = DIGITS*PRESCALE cycles.
- frame_done is high in the cycle after the boundary count, which is the first cycle display shows its new contents.
- Latency from load to the first pin change is at most DIGITS*PRESCALE+BLANK_CYCLES+1 cycles.
- Reset asserted mid-slot: outputs go inactive immediately (asynchronously); pending data is lost.

## Structure
- Shared package seg_pkg holds:
  - The 16-entry segment pattern constant and the segment bit-order constants.
  - The typedef seg_t (logic [6:0]).
- One natural sub-module is seg_hex_decode: combinational, nibble in, seg_t out, taken from the seg_pkg table. It is instantiated once on the muxed digit, after blanking is decided.
- Prescaler, index, shadow/display and output registers live in seg_scan_driver.

## Test plan
The bench uses DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0.
- Reset: hold rst_n=0 with enable=1 → an=1111, seg=0000000, dp_out=0, frame_done=0. Release → first an=1110 appears 3 cycles later.
- Decode: load 16'h12A0, dp=0100, wait two frames →
  - an=1110: seg=1111110.
  - an=1101: seg=1110111.
  - an=1011: seg=1101101, dp_out=1.
  - an=0111: seg=0110000.
  - frame_done period is 32 cycles.
- Blanking: blank_lz=1 →
  - Load 16'h0050: an=0111 and 1011 never occur; digit1 seg=1011011, digit0 seg=1111110.
  - Load 16'h0000: only an=1110 with seg=1111110.
- Tear-free update:
  - Load 16'h1111 then 16'h2222 mid-frame → display changes only at frame_done, shows 2, and 1 never appears.
  - Load 16'h3333 on a boundary cycle → 3 is shown in the following frame.
- Enable: drop enable during digit 2 → next cycle an=1111. Reassert → slot 0 restarts with 2 dead cycles, then an=1110.
- Async reset mid-scan: assert rst_n=0 between clock edges → an=1111 with no clock edge; display=0 after release.
